// File: rtl/onehot_splitter.sv
// onehot_splitter: decomposes a word into a stream of one-hot masks, lowest set bit first
module onehot_splitter #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mask,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] res, res_nxt, rest;
  logic [IDX_W-1:0] low_idx;
  logic emit, beat, take;
  assign rest = res & (res - WIDTH'(1));
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (res[i]) low_idx = IDX_W'(i);
  end
  assign emit      = !rst && state == EMIT;
  assign out_valid = emit;
  assign out_mask  = emit ? res & (~res + WIDTH'(1)) : '0;
  assign out_index = emit ? low_idx : '0;
  assign out_last  = emit && rest == '0;
  assign beat      = out_valid && out_ready;
  // the last-beat handshake reopens the input so words can run back-to-back
  assign in_ready  = !rst && (state == IDLE || (beat && out_last));
  assign take      = in_valid && in_ready;
  always_comb begin
    state_nxt = take ? EMIT : (beat && out_last) ? IDLE : state;
    res_nxt   = take ? in_data : beat ? rest : res;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      res   <= '0;
    end else begin
      state <= state_nxt;
      res   <= res_nxt;
    end
  end
endmodule

// File: tb/tb_onehot_splitter.sv
// tb_onehot_splitter: scoreboard bench driving directed words and checking every emitted beat
module tb_onehot_splitter;
  typedef struct packed {
    logic [31:0] mask;
    logic [4:0]  index;
    logic        last;
  } beat_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_last;
  logic [31:0] in_data = '0, out_mask;
  logic [4:0] out_index;
  beat_t exp_q[$];
  int tests = 0, fails = 0;
  logic prev_stall = 0;
  beat_t held;

  onehot_splitter #(.WIDTH(32), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
    .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) prev_stall <= 0;
    else begin
      check("in_ready_rule", 64'(in_ready), 64'(!out_valid || (out_ready && out_last)));
      if (prev_stall)
        check("stall_hold", 64'({out_valid, out_mask, out_index, out_last}), 64'({1'b1, held}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'({out_mask, out_index, out_last}), 64'(0));
        else check("beat", 64'({out_mask, out_index, out_last}), 64'(exp_q.pop_front()));
      end
      prev_stall <= out_valid && !out_ready;
      held <= '{out_mask, out_index, out_last};
    end
  end

  task automatic push(input logic [31:0] m, input logic [4:0] i, input logic l);
    exp_q.push_back('{m, i, l});
  endtask

  task automatic send(input logic [31:0] w);
    bit ok = 0;
    @(posedge clk); #1 in_valid = 1; in_data = w;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) check("accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(posedge clk); #2;
      ok = exp_q.size() == 0 && !out_valid;
    end
    if (!ok) check("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 64'({in_ready, out_valid, out_mask, out_index, out_last}), 64'(0));
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready), 64'(1));

    push(32'h0, 5'd0, 1'b1);
    send(32'h0);
    drain();
    @(negedge clk);
    check("ready_after_zero", 64'({in_ready, out_valid}), 64'(2'b10));

    push(32'h1, 5'd0, 1'b0);
    push(32'h8000_0000, 5'd31, 1'b1);
    send(32'h8000_0001);
    drain();

    for (int i = 0; i < 32; i++) push(32'h1 << i, 5'(i), i == 31);
    send(32'hFFFF_FFFF);
    drain();

    out_ready = 0;
    push(32'h20, 5'd5, 1'b0);
    push(32'h80, 5'd7, 1'b1);
    send(32'hA0);
    repeat (3) begin
      @(negedge clk);
      check("bp_first_beat", 64'({out_valid, out_mask, out_index, out_last}), 64'({1'b1, 32'h20, 5'd5, 1'b0}));
    end
    @(posedge clk); #1 out_ready = 1;
    drain();

    push(32'h2, 5'd1, 1'b0);
    push(32'h4, 5'd2, 1'b1);
    push(32'h1, 5'd0, 1'b1);
    @(posedge clk); #1 in_valid = 1; in_data = 32'h6;
    @(negedge clk);
    check("b2b_ready_idle", 64'(in_ready), 64'(1));
    @(posedge clk); #1 in_data = 32'h1;
    @(negedge clk);
    check("b2b_beat1", 64'({out_valid, in_ready}), 64'(2'b10));
    @(negedge clk);
    check("b2b_beat2", 64'({out_valid, in_ready, out_last}), 64'(3'b111));
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    check("b2b_beat3", 64'({out_valid, out_index, out_last}), 64'({1'b1, 5'd0, 1'b1}));
    drain();

    push(32'h1, 5'd0, 1'b0);
    push(32'h2, 5'd1, 1'b0);
    send(32'hF);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    check("mid_reset_outs", 64'({in_ready, out_valid, out_mask, out_index, out_last}), 64'(0));
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("post_reset_idle", 64'({in_ready, out_valid}), 64'(2'b10));
    push(32'h10, 5'd4, 1'b1);
    send(32'h10);
    drain();

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/onehot_splitter.md
# onehot_splitter

Multi-cycle bit-decomposition unit for the processor datapath: the inverse of the bitwise-OR combine. The OR op merges one-hot masks into a word. This block accepts a 32-bit word and emits it back as a stream of one-hot masks, one per set bit, lowest bit first, each with its bit index. It serves register-list expansion and multi-source interrupt/flag dispatch. Both sides use a valid/ready handshake.

## Interface

Parameters:
- WIDTH, 32, data word width
- IDX_W, 5, index width; must equal clog2(WIDTH)

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WIDTH  word to decompose
- out_valid  output  1  current beat is valid
- out_ready  input  1  downstream accepts the beat this cycle
- out_mask  output  WIDTH  one-hot mask of the current set bit (all zero for a zero word)
- out_index  output  IDX_W  bit position of out_mask (0 for a zero word)
- out_last  output  1  final beat of the current word

## Operation

- State: a residual register res[WIDTH-1:0] and a 2-state FSM {IDLE, EMIT}.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid && in_ready: res <= in_data, go to EMIT.
- EMIT:
  - out_valid=1.
  - out_mask = res & (~res + 1), the lowest set bit.
  - out_index = position of that bit.
  - out_last = ((res & (res - 1)) == 0).
- On out_valid && out_ready:
  - res <= res & (res - 1).
  - If out_last, the word is complete.
- Zero word: exactly one beat is emitted, with out_mask=0, out_index=0, out_last=1. Every accepted word yields at least one beat.
- Beat count per word = max(1, popcount(in_data)). Masks are emitted in strictly ascending index order.
- Back-to-back: in_ready is also 1 in EMIT when out_valid && out_ready && out_last.
  - If in_valid is high in that same cycle, the new word loads res and the FSM stays in EMIT.
  - Otherwise the FSM goes to IDLE.
- No other accept point exists; in_ready=0 in EMIT otherwise.
- Output stability: while out_valid && !out_ready, out_mask, out_index and out_last must hold constant.
- Inputs are not sampled while in_ready=0.
- No combinational path from in_data/in_valid to any out_* signal. The only combinational input-to-output path is out_ready to in_ready.
- Reset:
  - While rst=1: FSM <= IDLE, res <= 0, in_ready=0, out_valid=0, out_mask=0, out_index=0, out_last=0.
  - Reset mid-word discards the remaining beats.
  - The first cycle after rst deasserts shows in_ready=1.

## Timing

- Latency: a word accepted at edge N gives its first beat with out_valid=1 in the cycle after edge N.
- Throughput: one beat per cycle with out_ready held high.
- A word of k set bits (k≥1) occupies k cycles.
- With back-to-back accept there are zero idle cycles between words.
- Sustained rate is max(1, popcount) cycles per word.
- Simultaneous in handshake and last out handshake in the same cycle are both honoured. The new word's first beat appears next cycle.

## Test plan

- in_data=0x00000000 -> exactly one beat, mask=0x00000000, index=0, last=1; then in_ready=1.
- in_data=0x80000001 -> beat 1: mask=0x00000001, index=0, last=0; beat 2: mask=0x80000000, index=31, last=1.
- in_data=0xFFFFFFFF with out_ready=1 -> 32 consecutive beats, index 0..31, mask=1<<index, last only on index 31; in_ready=0 throughout until the final beat.
- Backpressure: in_data=0x000000A0, out_ready low for 3 cycles on the first beat -> mask=0x20, index=5 held stable for 4 cycles; then mask=0x80, index=7, last=1.
- Back-to-back: 0x00000006 then 0x00000001 with in_valid held high -> beats (1),(2,last),(0,last) on 3 consecutive cycles with no gap.
- Reset mid-word: in_data=0x0000000F, rst=1 after the second beat -> next cycle all outputs 0 and in_ready=0; after rst low, in_ready=1 and no residual beats; new word 0x10 yields a single beat, index=4, last=1.
